// File: rtl/quadrature_decoder_pkg.sv
// rtl/quadrature_decoder_pkg.sv - phase encodings, direction constants and step decode for the quadrature decoder
package quad_decoder_pkg;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic {
        ST_UNPRIMED = 1'b0,
        ST_PRIMED   = 1'b1
    } prime_state_t;

    typedef struct packed {
        logic valid;
        logic illegal;
        logic dir;
    } step_info_t;

    // Up order is 00 -> 01 -> 11 -> 10 -> 00; no change yields an all-zero result.
    function automatic step_info_t decode_step(input logic [1:0] prev, input logic [1:0] curr);
        step_info_t res;
        res = '0;
        case ({prev, curr})
            {PH_00, PH_01}, {PH_01, PH_11}, {PH_11, PH_10}, {PH_10, PH_00}: begin
                res.valid = 1'b1;
                res.dir   = DIR_UP;
            end
            {PH_01, PH_00}, {PH_11, PH_01}, {PH_10, PH_11}, {PH_00, PH_10}: begin
                res.valid = 1'b1;
                res.dir   = DIR_DOWN;
            end
            {PH_00, PH_11}, {PH_11, PH_00}, {PH_01, PH_10}, {PH_10, PH_01}: begin
                res.illegal = 1'b1;
            end
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/quadrature_decoder_if.sv
// rtl/quadrature_decoder_if.sv - control, encoder pins and position outputs of the quadrature decoder
interface quadrature_decoder_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             clear;
    logic             quad_a;
    logic             quad_b;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             step;
    logic             error;
    logic             error_flag;
    logic             max_count;
    logic             min_count;

    modport master (
        output enable, clear, quad_a, quad_b,
        input  count, dir, step, error, error_flag, max_count, min_count
    );

    modport slave (
        input  enable, clear, quad_a, quad_b,
        output count, dir, step, error, error_flag, max_count, min_count
    );
endinterface

// File: rtl/quadrature_decoder_input_filter.sv
// rtl/quadrature_decoder_input_filter.sv - two-flop synchroniser plus run-length glitch filter for one encoder phase
module quad_input_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_changed,
    output logic o_stable
);
    localparam logic [3:0] RUN_LAST = 4'(FILTER_LEN - 1);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_level;
    logic       r_changed;
    logic [3:0] r_run;

    // Any edge where the synchronised value matches the filtered level restarts the run.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_changed <= 1'b0;
            r_run     <= 4'd0;
        end else begin
            r_sync1   <= i_pin;
            r_sync2   <= r_sync1;
            r_changed <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_run == RUN_LAST) begin
                    r_level   <= r_sync2;
                    r_changed <= 1'b1;
                    r_run     <= 4'd0;
                end else begin
                    r_run <= r_run + 4'd1;
                end
            end else begin
                r_run <= 4'd0;
            end
        end
    end

    assign o_level   = r_level;
    assign o_changed = r_changed;
    assign o_stable  = (r_sync2 == r_level);

endmodule

// File: rtl/quadrature_decoder.sv
// rtl/quadrature_decoder.sv - filtered quadrature decode into step pulses and a wrapping position count
module quadrature_decoder
    import quad_decoder_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int INIT_VALUE = 0,
    parameter int FILTER_LEN = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    quadrature_decoder_if.slave bus
);
    localparam logic [WIDTH-1:0] INIT_C     = WIDTH'(INIT_VALUE);
    localparam logic [WIDTH-1:0] ONE_C      = WIDTH'(1);
    localparam logic [3:0]       PRIME_LAST = 4'(FILTER_LEN - 1);

    logic w_a_level;
    logic w_a_changed;
    logic w_a_stable;
    logic w_b_level;
    logic w_b_changed;
    logic w_b_stable;

    quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .i_clk     (clk),
        .i_rst_n   (reset_n),
        .i_pin     (bus.quad_a),
        .o_level   (w_a_level),
        .o_changed (w_a_changed),
        .o_stable  (w_a_stable)
    );

    quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .i_clk     (clk),
        .i_rst_n   (reset_n),
        .i_pin     (bus.quad_b),
        .o_level   (w_b_level),
        .o_changed (w_b_changed),
        .o_stable  (w_b_stable)
    );

    prime_state_t     r_state;
    prime_state_t     w_state_nxt;
    logic [3:0]       r_prime_cnt;
    logic [3:0]       w_prime_cnt_nxt;
    logic [1:0]       r_prev;
    logic [WIDTH-1:0] r_count;
    logic             r_dir;
    logic             r_step;
    logic             r_error;
    logic             r_error_flag;

    logic [1:0]       w_curr;
    logic             w_any_change;
    logic             w_all_stable;
    step_info_t       w_info;
    logic             w_load_ref;
    logic             w_step_ok;
    logic             w_err_ok;

    assign w_curr       = {w_a_level, w_b_level};
    assign w_any_change = w_a_changed | w_b_changed;
    assign w_all_stable = w_a_stable & w_b_stable;
    assign w_info       = decode_step(r_prev, w_curr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_UNPRIMED;
            r_prime_cnt <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_prime_cnt <= w_prime_cnt_nxt;
        end
    end

    // Unprimed: the first accepted filtered state (a filter change or FILTER_LEN quiet cycles) becomes the reference silently.
    always_comb begin
        w_state_nxt     = r_state;
        w_prime_cnt_nxt = r_prime_cnt;
        w_load_ref      = 1'b0;
        w_step_ok       = 1'b0;
        w_err_ok        = 1'b0;
        case (r_state)
            ST_UNPRIMED: begin
                if (w_any_change || (w_all_stable && (r_prime_cnt == PRIME_LAST))) begin
                    w_state_nxt     = ST_PRIMED;
                    w_load_ref      = 1'b1;
                    w_prime_cnt_nxt = 4'd0;
                end else if (w_all_stable) begin
                    w_prime_cnt_nxt = r_prime_cnt + 4'd1;
                end else begin
                    w_prime_cnt_nxt = 4'd0;
                end
            end
            ST_PRIMED: begin
                w_load_ref = (w_curr != r_prev);
                w_step_ok  = bus.enable & w_info.valid;
                w_err_ok   = bus.enable & w_info.illegal;
            end
            default: w_state_nxt = ST_UNPRIMED;
        endcase
    end

    // The reference follows the filtered state even when a step is masked, so re-enabling never sees a stale jump.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev       <= PH_00;
            r_count      <= INIT_C;
            r_dir        <= DIR_UP;
            r_step       <= 1'b0;
            r_error      <= 1'b0;
            r_error_flag <= 1'b0;
        end else begin
            r_step  <= 1'b0;
            r_error <= 1'b0;
            if (w_load_ref) begin
                r_prev <= w_curr;
            end
            if (bus.clear) begin
                r_count      <= INIT_C;
                r_error_flag <= 1'b0;
            end else begin
                if (w_step_ok) begin
                    r_step <= 1'b1;
                    r_dir  <= w_info.dir;
                    if (w_info.dir == DIR_UP) begin
                        r_count <= r_count + ONE_C;
                    end else begin
                        r_count <= r_count - ONE_C;
                    end
                end
                if (w_err_ok) begin
                    r_error      <= 1'b1;
                    r_error_flag <= 1'b1;
                end
            end
        end
    end

    assign bus.count      = r_count;
    assign bus.dir        = r_dir;
    assign bus.step       = r_step;
    assign bus.error      = r_error;
    assign bus.error_flag = r_error_flag;
    assign bus.max_count  = (r_count == {WIDTH{1'b1}}) && (r_dir == DIR_UP);
    assign bus.min_count  = (r_count == {WIDTH{1'b0}}) && (r_dir == DIR_DOWN);

endmodule

// File: tb/tb_quadrature_decoder.sv
// tb/tb_quadrature_decoder.sv - vector table plus step/error scoreboard for quadrature_decoder
module tb_quadrature_decoder;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    quadrature_decoder_if #(.WIDTH(8)) bus ();

    quadrature_decoder #(
        .WIDTH      (8),
        .INIT_VALUE (0),
        .FILTER_LEN (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        bit         is_err;
        logic [7:0] cnt;
        logic       dir;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [1:0] ab;
        logic       en;
        logic       exp_step;
        logic       exp_err;
        logic [7:0] exp_count;
        logic       exp_dir;
        logic       exp_flag;
        logic       exp_max;
        logic       exp_min;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic drive_ab(input logic [1:0] ab);
        bus.quad_a = ab[1];
        bus.quad_b = ab[0];
    endtask

    // Drive at a falling edge (cycle k); the pin is sampled at edge k+1 and the pulse appears after edge k+6.
    task automatic push_exp(input bit is_err, input logic [7:0] cnt, input logic dir);
        exp_t e;
        e.is_err = is_err;
        e.cnt    = cnt;
        e.dir    = dir;
        e.cyc    = cyc + 6;
        sb_q.push_back(e);
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] cnt, input logic dir,
                                 input logic flag, input logic mx, input logic mn);
        check({tag, " count"}, 32'(bus.count), 32'(cnt));
        check({tag, " dir"}, 32'(bus.dir), 32'(dir));
        check({tag, " error_flag"}, 32'(bus.error_flag), 32'(flag));
        check({tag, " max_count"}, 32'(bus.max_count), 32'(mx));
        check({tag, " min_count"}, 32'(bus.min_count), 32'(mn));
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && (bus.step === 1'b1 || bus.error === 1'b1)) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected: step=%0b error=%0b count=%0d at cycle %0d, expected no pulse",
                         bus.step, bus.error, bus.count, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_kind", {30'd0, bus.step, bus.error}, mon_e.is_err ? 32'd1 : 32'd2);
                check("sb_count", 32'(bus.count), 32'(mon_e.cnt));
                check("sb_dir", 32'(bus.dir), 32'(mon_e.dir));
                check("sb_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    initial begin
        //             ab     en    stp   err   count    dir   flag  max   min
        vecs[0]  = '{2'b01, 1'b1, 1'b1, 1'b0, 8'd1,   1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{2'b11, 1'b1, 1'b1, 1'b0, 8'd2,   1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{2'b10, 1'b1, 1'b1, 1'b0, 8'd3,   1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{2'b00, 1'b1, 1'b1, 1'b0, 8'd4,   1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{2'b10, 1'b1, 1'b1, 1'b0, 8'd3,   1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{2'b11, 1'b1, 1'b1, 1'b0, 8'd2,   1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{2'b01, 1'b1, 1'b1, 1'b0, 8'd1,   1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{2'b00, 1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{2'b10, 1'b1, 1'b1, 1'b0, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{2'b11, 1'b1, 1'b1, 1'b0, 8'd254, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{2'b10, 1'b1, 1'b1, 1'b0, 8'd255, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{2'b00, 1'b1, 1'b1, 1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{2'b11, 1'b1, 1'b0, 1'b1, 8'd0,   1'b1, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{2'b10, 1'b1, 1'b1, 1'b0, 8'd1,   1'b1, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{2'b00, 1'b0, 1'b0, 1'b0, 8'd1,   1'b1, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{2'b01, 1'b0, 1'b0, 1'b0, 8'd1,   1'b1, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{2'b11, 1'b0, 1'b0, 1'b0, 8'd1,   1'b1, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{2'b10, 1'b1, 1'b1, 1'b0, 8'd2,   1'b1, 1'b1, 1'b0, 1'b0};

        reset_n    = 1'b0;
        bus.enable = 1'b1;
        bus.clear  = 1'b0;
        drive_ab(2'b00);
        repeat (3) @(negedge clk);
        check_outputs("reset", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("reset step", 32'(bus.step), 32'd0);
        check("reset error", 32'(bus.error), 32'd0);
        reset_n = 1'b1;

        repeat (10) @(negedge clk);
        check_outputs("primed", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            bus.enable = vecs[i].en;
            drive_ab(vecs[i].ab);
            if (vecs[i].exp_step || vecs[i].exp_err)
                push_exp(vecs[i].exp_err, vecs[i].exp_count, vecs[i].exp_dir);
            repeat (8) @(negedge clk);
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_dir,
                          vecs[i].exp_flag, vecs[i].exp_max, vecs[i].exp_min);
        end

        // Two-cycle glitch on phase A from AB=10 must be rejected.
        @(negedge clk);
        bus.quad_a = 1'b0;
        repeat (2) @(negedge clk);
        bus.quad_a = 1'b1;
        repeat (10) @(negedge clk);
        check("glitch count", 32'(bus.count), 32'd2);

        // Clear lands on the same edge as the 10->00 up step; the step is swallowed.
        @(negedge clk);
        drive_ab(2'b00);
        repeat (5) @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        repeat (4) @(negedge clk);
        check("clear count", 32'(bus.count), 32'd0);
        check("clear error_flag", 32'(bus.error_flag), 32'd0);

        @(negedge clk);
        drive_ab(2'b10);
        push_exp(1'b0, 8'd255, 1'b0);
        repeat (8) @(negedge clk);
        check_outputs("after_clear", 8'd255, 1'b0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        drive_ab(2'b01);
        push_exp(1'b1, 8'd255, 1'b0);
        repeat (8) @(negedge clk);
        check_outputs("illegal2", 8'd255, 1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset while an illegal 01->10 change is still in the filters.
        @(negedge clk);
        drive_ab(2'b10);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_outputs("async_reset", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        check_outputs("reprime", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        drive_ab(2'b00);
        push_exp(1'b0, 8'd1, 1'b1);
        repeat (8) @(negedge clk);
        check_outputs("post_reprime", 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);

        check("sb_pending", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
